// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity codes.
// Used by both the transmit frame generator and the receive-side parity checker.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Turns the XOR-reduce of the data into the parity bit for the selected type.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit shift register and bit counter for the UART transmitter.
// serial_bit is the data bit to be driven on the line after the next clock edge.
module uart_tx_serializer #(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   CLK_tx,
  input  logic                   RST_tx,
  input  logic                   load,
  input  logic                   shift,
  input  logic [DATA_LENGTH-1:0] data,
  output logic                   serial_bit,
  output logic                   done
);

  localparam int CW = $clog2(DATA_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_LENGTH - 1);

  // Holds the data bits not yet on the line; bit 0 is placed on the line
  // directly from the load value, so only the upper bits are stored.
  logic [DATA_LENGTH-2:0] shreg_q;
  logic [CW-1:0]          cnt_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_tx) begin
    if (RST_tx) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shreg_q <= data[DATA_LENGTH-1:1];
      cnt_q   <= '0;
    end else if (shift) begin
      shreg_q <= {1'b0, shreg_q[DATA_LENGTH-2:1]};
      if (cnt_q != LAST) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // cnt_q equals the index of the data bit currently on the line.
  assign done       = (cnt_q == LAST);
  assign serial_bit = load ? data[0] : shreg_q[0];

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one start/data/parity/stop frame per request,
// one bit per baud-rate clock, with back-to-back frames accepted during STOP.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   CLK_tx,
  input  logic                   RST_tx,
  input  logic [DATA_LENGTH-1:0] P_DATA_tx,
  input  logic                   DATA_VALID_tx,
  input  logic                   PAR_EN_tx,
  input  logic                   PAR_TYP_tx,
  output logic                   TX_OUT_tx,
  output logic                   busy_tx
);

  uart_state_e            state_q, state_d;
  logic [DATA_LENGTH-1:0] data_q;
  logic                   par_en_q;
  logic                   par_typ_q;
  logic                   tx_q, tx_d;
  logic                   busy_q;

  logic accept;
  logic ser_load, ser_shift, ser_bit, ser_done;

  assign accept    = DATA_VALID_tx && ((state_q == IDLE) || (state_q == STOP));
  assign ser_load  = (state_q == START);
  assign ser_shift = (state_q == DATA) && !ser_done;

  uart_tx_serializer #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_serializer (
    .CLK_tx    (CLK_tx),
    .RST_tx    (RST_tx),
    .load      (ser_load),
    .shift     (ser_shift),
    .data      (data_q),
    .serial_bit(ser_bit),
    .done      (ser_done)
  );

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = DATA;
      DATA:    if (ser_done) state_d = par_en_q ? PARITY : STOP;
      PARITY:  state_d = STOP;
      STOP:    state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The line level is chosen from the next state and registered, so the pin
  // comes straight from a flop and never glitches.
  always_comb begin
    tx_d = LINE_IDLE;
    unique case (state_d)
      IDLE:    tx_d = LINE_IDLE;
      START:   tx_d = START_BIT;
      DATA:    tx_d = ser_bit;
      PARITY:  tx_d = parity_bit(^data_q, par_typ_q);
      STOP:    tx_d = STOP_BIT;
      default: tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK_tx) begin
    if (RST_tx) begin
      state_q   <= IDLE;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        data_q    <= P_DATA_tx;
        par_en_q  <= PAR_EN_tx;
        par_typ_q <= PAR_TYP_tx;
      end
    end
  end

  assign TX_OUT_tx = tx_q;
  assign busy_tx   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed and random frames compared
// against a frame model built from the serial framing rules.
module tb_uart_tx_frame;

  localparam int DL = 8;

  logic          CLK_tx;
  logic          RST_tx;
  logic [DL-1:0] P_DATA_tx;
  logic          DATA_VALID_tx;
  logic          PAR_EN_tx;
  logic          PAR_TYP_tx;
  logic          TX_OUT_tx;
  logic          busy_tx;

  int checks = 0;
  int errors = 0;

  uart_tx_frame #(
    .DATA_LENGTH(DL)
  ) dut (
    .CLK_tx       (CLK_tx),
    .RST_tx       (RST_tx),
    .P_DATA_tx    (P_DATA_tx),
    .DATA_VALID_tx(DATA_VALID_tx),
    .PAR_EN_tx    (PAR_EN_tx),
    .PAR_TYP_tx   (PAR_TYP_tx),
    .TX_OUT_tx    (TX_OUT_tx),
    .busy_tx      (busy_tx)
  );

  initial begin
    CLK_tx = 1'b0;
    forever #5 CLK_tx = ~CLK_tx;
  end

  // Reference model: line bits of one frame, index 0 = start bit.
  function automatic logic [31:0] exp_frame(input logic [DL-1:0] d, input logic en,
                                            input logic typ);
    logic [31:0] f;
    int n;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < DL; i++) f[1+i] = d[i];
    n = DL + 1;
    if (en) begin
      f[n] = (($countones(d) % 2) == 1) ^ typ;
      n++;
    end
    f[n] = 1'b1;
    return f;
  endfunction

  function automatic int frame_len(input logic en);
    return DL + (en ? 3 : 2);
  endfunction

  // Issues a one-cycle request; returns at the falling edge of the start-bit cycle.
  task automatic start_req(input logic [DL-1:0] d, input logic en, input logic typ);
    @(negedge CLK_tx);
    P_DATA_tx     = d;
    PAR_EN_tx     = en;
    PAR_TYP_tx    = typ;
    DATA_VALID_tx = 1'b1;
    @(negedge CLK_tx);
    DATA_VALID_tx = 1'b0;
  endtask

  // Samples line and busy on n consecutive falling edges, starting with the current one.
  task automatic capture(input int n, output logic [31:0] s_tx, output logic [31:0] s_busy);
    s_tx = '0;
    s_busy = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK_tx);
      s_tx[i]   = TX_OUT_tx;
      s_busy[i] = busy_tx;
    end
  endtask

  task automatic test_reset();
    RST_tx = 1'b1;
    DATA_VALID_tx = 1'b0;
    P_DATA_tx = '0;
    PAR_EN_tx = 1'b0;
    PAR_TYP_tx = 1'b0;
    repeat (2) @(negedge CLK_tx);
    checks++;
    if (TX_OUT_tx !== 1'b1 || busy_tx !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx=%b busy=%b expected tx=1 busy=0", TX_OUT_tx, busy_tx);
    end
    DATA_VALID_tx = 1'b1;
    P_DATA_tx = 8'hA5;
    @(negedge CLK_tx);
    checks++;
    if (TX_OUT_tx !== 1'b1 || busy_tx !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_valid tx=%b busy=%b expected tx=1 busy=0", TX_OUT_tx, busy_tx);
    end
    DATA_VALID_tx = 1'b0;
    RST_tx = 1'b0;
    repeat (2) @(negedge CLK_tx);
    checks++;
    if (TX_OUT_tx !== 1'b1 || busy_tx !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset tx=%b busy=%b expected tx=1 busy=0", TX_OUT_tx, busy_tx);
    end
  endtask

  task automatic test_parity_frames();
    logic [DL-1:0] d_tab[4] = '{8'hA5, 8'hA5, 8'h00, 8'hFF};
    logic          t_tab[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic          p_tab[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [10:0]   a5_even = 11'b10101001010;
    logic [31:0]   s_tx, s_busy, e;
    int            n;
    for (int k = 0; k < 4; k++) begin
      n = frame_len(1'b1);
      e = exp_frame(d_tab[k], 1'b1, t_tab[k]);
      start_req(d_tab[k], 1'b1, t_tab[k]);
      capture(n + 1, s_tx, s_busy);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (s_tx[i] !== e[i] || s_busy[i] !== 1'b1) begin
          errors++;
          $display("FAIL parity_frame%0d bit%0d tx=%b busy=%b expected tx=%b busy=1",
                   k, i, s_tx[i], s_busy[i], e[i]);
        end
      end
      checks++;
      if (s_tx[DL+1] !== p_tab[k]) begin
        errors++;
        $display("FAIL parity_slot%0d data=%h typ=%b got=%b expected=%b",
                 k, d_tab[k], t_tab[k], s_tx[DL+1], p_tab[k]);
      end
      checks++;
      if (s_tx[n] !== 1'b1 || s_busy[n] !== 1'b0) begin
        errors++;
        $display("FAIL parity_idle%0d tx=%b busy=%b expected tx=1 busy=0", k, s_tx[n], s_busy[n]);
      end
      if (k == 0) begin
        checks++;
        if (s_tx[10:0] !== a5_even) begin
          errors++;
          $display("FAIL a5_even_sequence got=%b expected=%b (bit0 rightmost)", s_tx[10:0], a5_even);
        end
      end
    end
  endtask

  task automatic test_no_parity();
    logic [9:0]  lit = 10'b1001111000;
    logic [31:0] s_tx, s_busy;
    start_req(8'h3C, 1'b0, 1'b1);
    capture(11, s_tx, s_busy);
    checks++;
    if (s_tx[9:0] !== lit || s_busy[9:0] !== 10'h3FF) begin
      errors++;
      $display("FAIL no_parity_frame tx=%b busy=%b expected tx=%b busy=1111111111",
               s_tx[9:0], s_busy[9:0], lit);
    end
    checks++;
    if (s_tx[10] !== 1'b1 || s_busy[10] !== 1'b0) begin
      errors++;
      $display("FAIL no_parity_idle tx=%b busy=%b expected tx=1 busy=0", s_tx[10], s_busy[10]);
    end
  endtask

  task automatic test_random();
    logic [DL-1:0] d;
    logic          en, typ;
    logic [31:0]   s_tx, s_busy, e, mask;
    int            n;
    for (int k = 0; k < 24; k++) begin
      d   = DL'($urandom);
      en  = 1'($urandom);
      typ = 1'($urandom);
      n   = frame_len(en);
      e   = exp_frame(d, en, typ);
      mask = (32'd1 << n) - 32'd1;
      start_req(d, en, typ);
      capture(n + 1, s_tx, s_busy);
      checks++;
      if ((s_tx & mask) !== e || (s_busy & mask) !== mask || s_tx[n] !== 1'b1 || s_busy[n] !== 1'b0) begin
        errors++;
        $display("FAIL random_frame%0d data=%h en=%b typ=%b tx=%b busy=%b expected tx=%b busy=%b",
                 k, d, en, typ, s_tx, s_busy, e | (32'd1 << n), mask);
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK_tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2, s_tx, s_busy;
    logic        exp_tx, exp_busy;
    e1 = exp_frame(8'h55, 1'b0, 1'b0);
    e2 = exp_frame(8'h0F, 1'b0, 1'b0);
    @(negedge CLK_tx);
    P_DATA_tx = 8'h55;
    PAR_EN_tx = 1'b0;
    PAR_TYP_tx = 1'b0;
    DATA_VALID_tx = 1'b1;
    @(negedge CLK_tx);
    P_DATA_tx = 8'h0F;
    s_tx = '0;
    s_busy = '0;
    for (int i = 0; i < 21; i++) begin
      s_tx[i] = TX_OUT_tx;
      s_busy[i] = busy_tx;
      if (i == 10) DATA_VALID_tx = 1'b0;
      if (i < 20) @(negedge CLK_tx);
    end
    for (int i = 0; i < 21; i++) begin
      exp_tx   = (i < 10) ? e1[i] : (i < 20) ? e2[i-10] : 1'b1;
      exp_busy = (i < 20);
      checks++;
      if (s_tx[i] !== exp_tx || s_busy[i] !== exp_busy) begin
        errors++;
        $display("FAIL back_to_back cycle%0d tx=%b busy=%b expected tx=%b busy=%b",
                 i, s_tx[i], s_busy[i], exp_tx, exp_busy);
      end
    end
  endtask

  task automatic test_ignore_midframe();
    logic [DL-1:0] d;
    logic          typ;
    logic [31:0]   e, s_tx, s_busy;
    int            n;
    d   = DL'($urandom);
    typ = 1'($urandom);
    n   = frame_len(1'b1);
    e   = exp_frame(d, 1'b1, typ);
    start_req(d, 1'b1, typ);
    s_tx = '0;
    s_busy = '0;
    for (int i = 0; i <= n; i++) begin
      s_tx[i] = TX_OUT_tx;
      s_busy[i] = busy_tx;
      if (i == 3) begin
        DATA_VALID_tx = 1'b1;
        P_DATA_tx     = ~d;
        PAR_TYP_tx    = ~typ;
        PAR_EN_tx     = 1'b0;
      end
      if (i == 8) DATA_VALID_tx = 1'b0;
      if (i < n) @(negedge CLK_tx);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (s_tx[i] !== e[i] || s_busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL midframe_request bit%0d tx=%b busy=%b expected tx=%b busy=1",
                 i, s_tx[i], s_busy[i], e[i]);
      end
    end
    checks++;
    if (s_tx[n] !== 1'b1 || s_busy[n] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_dropped tx=%b busy=%b expected tx=1 busy=0", s_tx[n], s_busy[n]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] e, s_tx, s_busy;
    e = exp_frame(8'hA5, 1'b1, 1'b0);
    start_req(8'hA5, 1'b1, 1'b0);
    repeat (5) @(negedge CLK_tx);
    checks++;
    if (TX_OUT_tx !== e[5] || busy_tx !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bit4 tx=%b busy=%b expected tx=%b busy=1", TX_OUT_tx, busy_tx, e[5]);
    end
    RST_tx = 1'b1;
    @(negedge CLK_tx);
    checks++;
    if (TX_OUT_tx !== 1'b1 || busy_tx !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort tx=%b busy=%b expected tx=1 busy=0", TX_OUT_tx, busy_tx);
    end
    RST_tx = 1'b0;
    @(negedge CLK_tx);
    checks++;
    if (TX_OUT_tx !== 1'b1 || busy_tx !== 1'b0) begin
      errors++;
      $display("FAIL after_abort_idle tx=%b busy=%b expected tx=1 busy=0", TX_OUT_tx, busy_tx);
    end
    start_req(8'hA5, 1'b1, 1'b0);
    capture(12, s_tx, s_busy);
    checks++;
    if (s_tx[10:0] !== e[10:0] || s_busy[10:0] !== 11'h7FF || s_tx[11] !== 1'b1 || s_busy[11] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_frame tx=%b busy=%b expected tx=%b busy=%b",
               s_tx[11:0], s_busy[11:0], {1'b1, e[10:0]}, 12'h7FF);
    end
  endtask

  initial begin
    test_reset();
    test_parity_frames();
    test_no_parity();
    test_random();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter, the transmit-side counterpart of the RX parity checker. Accepts a parallel byte with a valid strobe, then serialises one frame on TX_OUT_tx, one bit per CLK_tx cycle: start, data LSB-first, optional parity, stop. CLK_tx runs at the baud rate; oversampling is not done here. Parity type encoding matches the RX checker, so a looped-back frame reports no parity error.

Parameters:
DATA_LENGTH, 8, data bits per frame (valid range 5..9)

Ports:
CLK_tx  input  1  baud-rate clock; all state changes on the rising edge
RST_tx  input  1  synchronous, active-high reset
P_DATA_tx  input  DATA_LENGTH  parallel data; captured on accept
DATA_VALID_tx  input  1  single-cycle or held request to send P_DATA_tx
PAR_EN_tx  input  1  1 = insert parity bit; captured on accept
PAR_TYP_tx  input  1  0 = even, 1 = odd; captured on accept
TX_OUT_tx  output  1  serial line, idle high
busy_tx  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (RST_tx high at a rising edge): state IDLE, TX_OUT_tx = 1, busy_tx = 0. The bit counter and the data, parity-enable and type holding registers clear to 0. Reset mid-frame aborts the frame immediately. The line returns high on the next edge.
- States: IDLE -> START -> DATA -> PARITY (only if the captured PAR_EN is 1) -> STOP -> IDLE or START.
- Accept rule: accept = DATA_VALID_tx and (state is IDLE or STOP). On accept, P_DATA_tx, PAR_EN_tx and PAR_TYP_tx are registered. Next state is START.
- DATA_VALID_tx in START, DATA or PARITY is ignored. The frame is neither corrupted nor queued.
- Latency: accept at edge k gives TX_OUT_tx = 0 (start bit) from edge k+1.
- START: 1 cycle driving 0.
- DATA: DATA_LENGTH cycles, bit i (LSB first) driven in cycle i. The counter runs 0..DATA_LENGTH-1 and exits at DATA_LENGTH-1 without wrapping further.
- PARITY: 1 cycle. The bit is the XOR-reduce of the captured data when type is even, and its inverse when type is odd. It is computed from the captured data, never from the live input.
- STOP: 1 cycle driving 1.
- Frame length is DATA_LENGTH+3 cycles with parity and DATA_LENGTH+2 without.
- Back-to-back: DATA_VALID_tx high during STOP gives START on the next cycle. busy_tx stays 1 with no idle gap.
- TX_OUT_tx is a registered output (no combinational path from inputs) and is glitch-free.
- busy_tx is registered and asserted from edge k+1 through the STOP cycle.
- Input changes to P_DATA_tx, PAR_EN_tx or PAR_TYP_tx mid-frame have no effect on the frame in flight.

Decomposition:
- Shared uart package holds the state encodings (IDLE/START/DATA/PARITY/STOP, 3-bit), the line levels (LINE_IDLE = 1, START_BIT = 0, STOP_BIT = 1) and the parity type codes (EVEN = 0, ODD = 1). The RX side uses the same package.
- One natural sub-module, uart_tx_serializer: the shift register plus bit counter. Inputs are load, shift and captured data; outputs are serial bit and done. The FSM and output mux stay in uart_tx_frame.
- Parity generation is a single combinational reduce. It stays inline.

Test Plan:
- 0xA5, PAR_EN=1, PAR_TYP=0, one-cycle valid -> TX_OUT_tx sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles. busy_tx high for those 11 cycles, then idle high.
- 0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit 1. 0x00 with odd parity -> parity bit 1. 0xFF with even parity -> parity bit 0.
- 0x3C, PAR_EN=0 -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1. No parity slot.
- Valid held high for two bytes 0x55 then 0x0F, parity off -> second start bit directly follows the first stop bit. 20 contiguous busy cycles.
- New valid and changed P_DATA_tx/PAR_TYP_tx during DATA state -> current frame bits unchanged, request dropped, busy_tx falls after STOP.
- RST_tx pulsed during data bit 4 -> next cycle TX_OUT_tx=1 and busy_tx=0. A subsequent 0xA5 request transmits a correct full frame.
